// File: rtl/csr_host_initiator.sv
// CSR bus initiator: turns host valid/ready commands into single CSR accesses and returns responses.
// Optional statistics counters are enabled with `define CSR_HOST_INITIATOR_STATS_EN.

package csr_pkg;
    localparam int S_ADDR_WIDTH = 16;
    typedef logic [31:0] csr_data_t;
    typedef logic [31:0] csr_addr_t;
endpackage

module csr_host_initiator #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = csr_pkg::S_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  csr_pkg::csr_addr_t      cmd_addr,
    input  csr_pkg::csr_data_t      cmd_wdata,
    output logic                    csr_req,
    output logic                    csr_we,
    output logic [ADDR_W-1:0]       csr_addr,
    output csr_pkg::csr_data_t      csr_wdata,
    input  logic                    csr_ack,
    input  csr_pkg::csr_data_t      csr_rdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output csr_pkg::csr_data_t      rsp_rdata,
    output logic                    rsp_err
`ifdef CSR_HOST_INITIATOR_STATS_EN
    ,
    output logic [31:0]             stat_txn_cnt,
    output logic [31:0]             stat_timeout_cnt,
    output logic [31:0]             stat_addr_err_cnt
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             addr_legal;

    // Word aligned and no bits set above the bus address range.
    assign addr_legal = (cmd_addr[1:0] == 2'b00) && ((cmd_addr >> (ADDR_W + 2)) == '0);

`ifdef CSR_HOST_INITIATOR_STATS_EN
    logic rsp_is_timeout;
    logic rsp_is_addr_err;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            csr_req   <= 1'b0;
            csr_we    <= 1'b0;
            csr_addr  <= '0;
            csr_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef CSR_HOST_INITIATOR_STATS_EN
            rsp_is_timeout    <= 1'b0;
            rsp_is_addr_err   <= 1'b0;
            stat_txn_cnt      <= '0;
            stat_timeout_cnt  <= '0;
            stat_addr_err_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        if (addr_legal) begin
                            state     <= ISSUE;
                            csr_req   <= 1'b1;
                            csr_we    <= cmd_write;
                            csr_addr  <= cmd_addr[ADDR_W+1:2];
                            csr_wdata <= cmd_wdata;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
`ifdef CSR_HOST_INITIATOR_STATS_EN
                            rsp_is_timeout  <= 1'b0;
                            rsp_is_addr_err <= 1'b1;
`endif
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                // The issue cycle counts toward the timeout, so csr_req spans exactly TIMEOUT_CYCLES.
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= cnt + 1'b1;
                end
                WAIT: begin
                    if (csr_ack) begin
                        state     <= RESP;
                        csr_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= csr_we ? '0 : csr_rdata;
`ifdef CSR_HOST_INITIATOR_STATS_EN
                        rsp_is_timeout  <= 1'b0;
                        rsp_is_addr_err <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        csr_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
`ifdef CSR_HOST_INITIATOR_STATS_EN
                        rsp_is_timeout  <= 1'b1;
                        rsp_is_addr_err <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        cmd_ready <= 1'b1;
`ifdef CSR_HOST_INITIATOR_STATS_EN
                        if (stat_txn_cnt != '1) stat_txn_cnt <= stat_txn_cnt + 1'b1;
                        if (rsp_is_timeout && stat_timeout_cnt != '1)
                            stat_timeout_cnt <= stat_timeout_cnt + 1'b1;
                        if (rsp_is_addr_err && stat_addr_err_cnt != '1)
                            stat_addr_err_cnt <= stat_addr_err_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_host_initiator.sv
// Directed bench for csr_host_initiator with a response scoreboard; TIMEOUT_CYCLES=8.

module tb_csr_host_initiator;
    localparam int T_CYC = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        csr_req, csr_we;
    logic [15:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
`ifdef CSR_HOST_INITIATOR_STATS_EN
    logic [31:0] stat_txn_cnt, stat_timeout_cnt, stat_addr_err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    csr_host_initiator #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .csr_req   (csr_req),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_ack   (csr_ack),
        .csr_rdata (csr_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef CSR_HOST_INITIATOR_STATS_EN
        ,
        .stat_txn_cnt      (stat_txn_cnt),
        .stat_timeout_cnt  (stat_timeout_cnt),
        .stat_addr_err_cnt (stat_addr_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command and let it be accepted on the next edge.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic collect_rsp(input string tag);
        int   n = 0;
        rsp_t e;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_cmd_ready_busy"}, cmd_ready, 1'b0);
        checks++;
        assert (exp_q.size() > 0)
        else begin
            errors++;
            $error("FAIL %s_scoreboard: observed empty expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, rsp_valid, 1'b0);
        check({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int          n;
        logic [31:0] held;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        csr_ack   = 1'b0;
        csr_rdata = '0;
        rsp_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_csr_req", csr_req, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        check("post_rst_cmd_ready_high", cmd_ready, 1'b1);

        // Write, ack three cycles after csr_req; read data on the bus must not leak into the response
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("wr_req", csr_req, 1'b1);
        check("wr_we", csr_we, 1'b1);
        check("wr_addr", csr_addr, 16'h0004);
        check("wr_wdata", csr_wdata, 32'hDEAD_BEEF);
        tick();
        tick();
        tick();
        check("wr_req_held", csr_req, 1'b1);
        check("wr_addr_held", csr_addr, 16'h0004);
        csr_ack   = 1'b1;
        csr_rdata = 32'hAAAA_5555;
        tick();
        csr_ack   = 1'b0;
        check("wr_req_drop", csr_req, 1'b0);
        check("wr_rsp_latency", rsp_valid, 1'b1);
        collect_rsp("wr");

        // Read; an ack during the issue cycle is ignored
        exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        send_cmd(1'b0, 32'h0000_0008, 32'h0);
        check("rd_addr", csr_addr, 16'h0002);
        check("rd_we", csr_we, 1'b0);
        csr_ack   = 1'b1;
        csr_rdata = 32'hFFFF_0000;
        tick();
        csr_ack   = 1'b0;
        check("rd_issue_ack_ignored", rsp_valid, 1'b0);
        check("rd_req_still_high", csr_req, 1'b1);
        csr_ack   = 1'b1;
        csr_rdata = 32'h1234_5678;
        tick();
        csr_ack   = 1'b0;
        csr_rdata = 32'h0BAD_0BAD;
        check("rd_rsp_latency", rsp_valid, 1'b1);
        collect_rsp("rd");

        // Timeout: csr_req high exactly TIMEOUT_CYCLES cycles
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        send_cmd(1'b0, 32'h0000_0020, 32'h0);
        n = 0;
        while (csr_req && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, T_CYC);
        collect_rsp("to");

        // Ack in the same cycle the timeout would fire: ack wins
        exp_q.push_back('{rdata: 32'h5A5A_A5A5, err: 1'b0});
        send_cmd(1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < T_CYC - 1; i++) tick();
        check("race_req_high", csr_req, 1'b1);
        csr_ack   = 1'b1;
        csr_rdata = 32'h5A5A_A5A5;
        tick();
        csr_ack   = 1'b0;
        collect_rsp("race");

        // Illegal addresses: out of range and misaligned
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        send_cmd(1'b1, 32'h0004_0000, 32'h1111_1111);
        check("ill_range_no_req", csr_req, 1'b0);
        collect_rsp("ill_range");
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        send_cmd(1'b0, 32'h0000_0002, 32'h0);
        check("ill_align_no_req", csr_req, 1'b0);
        collect_rsp("ill_align");

        // Highest legal address
        exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        send_cmd(1'b0, 32'h0003_FFFC, 32'h0);
        check("max_addr_req", csr_req, 1'b1);
        check("max_addr", csr_addr, 16'hFFFF);
        tick();
        csr_ack   = 1'b1;
        csr_rdata = 32'hCAFE_F00D;
        tick();
        csr_ack   = 1'b0;
        collect_rsp("max");

`ifdef CSR_HOST_INITIATOR_STATS_EN
        check("stat_addr_err", stat_addr_err_cnt, 32'd2);
        check("stat_timeout", stat_timeout_cnt, 32'd1);
        check("stat_txn", stat_txn_cnt, 32'd7);
`endif

        // Backpressure: response held stable for 10 cycles, no new command accepted
        exp_q.push_back('{rdata: 32'h8765_4321, err: 1'b0});
        send_cmd(1'b0, 32'h0000_0100, 32'h0);
        tick();
        csr_ack   = 1'b1;
        csr_rdata = 32'h8765_4321;
        tick();
        csr_ack   = 1'b0;
        csr_rdata = 32'h0;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0004;
        held      = rsp_rdata;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_rdata", rsp_rdata, 32'h8765_4321);
            check("bp_cmd_ready", cmd_ready, 1'b0);
            check("bp_no_req", csr_req, 1'b0);
            tick();
        end
        check("bp_rdata_stable", rsp_rdata, held);
        cmd_valid = 1'b0;
        collect_rsp("bp");

        // Reset during WAIT: bus request drops asynchronously, no response afterwards
        send_cmd(1'b1, 32'h0000_0200, 32'h7777_7777);
        tick();
        tick();
        check("mid_req_before_rst", csr_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_async", csr_req, 1'b0);
        check("mid_rst_valid", rsp_valid, 1'b0);
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid || csr_req) n++;
        end
        rsp_ready = 1'b0;
        check("mid_rst_no_activity", n, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_host_initiator.md
Name: csr_host_initiator

Overview:
- CSR bus initiator, the requesting end of the CSR interface: accepts host read/write commands over a valid/ready channel and issues single CSR accesses.
- Collects responses, including timeout and range errors, and returns them on a valid/ready response channel.
- Sits between the host/debug interface and the CSR responder register block of the VDF engine.
- Uses csr_data_t (32 bit) data, csr_addr_t (32 bit) command addresses and S_ADDR_WIDTH (16) bus addresses from csr_pkg.

Parameters:
- TIMEOUT_CYCLES, 256: cycles to wait for csr_ack before flagging an error; legal range 2..65535.
- ADDR_W, csr_pkg::S_ADDR_WIDTH (16): width of the CSR bus address.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  32  byte address (csr_addr_t).
- cmd_wdata  in  32  write data (csr_data_t).
- csr_req  out  1  CSR access strobe, held until ack or timeout.
- csr_we  out  1  write enable, valid with csr_req.
- csr_addr  out  ADDR_W  CSR word address.
- csr_wdata  out  32  CSR write data.
- csr_ack  in  1  responder completion, one-cycle pulse.
- csr_rdata  in  32  read data, valid when csr_ack=1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout or illegal address.

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready.
  - cmd_ready reads 0 while rst_n=0 and goes to 1 in the first clock after deassertion.
  - FSM returns to IDLE.
  - Timeout counter cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register write/addr/wdata.
  - Address check: legal iff cmd_addr[1:0]==0 and cmd_addr[31:ADDR_W+2]==0.
  - Legal address -> ISSUE.
  - Illegal address -> RESP with rsp_err=1, rsp_rdata=0, and no bus access.
- ISSUE:
  - Drive csr_req=1, csr_we, csr_addr=cmd_addr[ADDR_W+1:2], csr_wdata for one cycle, then go to WAIT.
  - csr_req stays 1 in WAIT.
- WAIT:
  - csr_req=1 with bus signals held stable.
  - Counter increments each cycle.
  - csr_ack=1 -> capture csr_rdata (0 for writes), rsp_err=0, drop csr_req next cycle, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack -> rsp_err=1, rsp_rdata=0, drop csr_req, go to RESP.
  - Ack arriving in the same cycle as the timeout: ack wins (no error).
- csr_ack seen outside WAIT (including ISSUE) is ignored.
- Latency: command accept to csr_req = 1 cycle. Ack to rsp_valid = 1 cycle.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready -> IDLE.
  - cmd_ready=0 in RESP, so only one transaction is outstanding; no pipelining.
- Response data rules:
  - Read data is passed through unmodified.
  - Write responses carry rsp_rdata=0.
- Reset mid-transaction: csr_req and rsp_valid drop immediately (asynchronous); the pending transaction is discarded with no response.
- Timeout counter width: clog2(TIMEOUT_CYCLES); no wrap-around, because the counter stops on the timeout condition.

Optional Feature:
- Macro: CSR_HOST_INITIATOR_STATS_EN.
- When defined, adds three outputs, each 32-bit saturating (no wrap):
  - stat_txn_cnt: completed responses.
  - stat_timeout_cnt: timeouts.
  - stat_addr_err_cnt: illegal-address commands.
- Counters update on the rsp handshake and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write: cmd_addr=0x0000_0010, wdata=0xDEAD_BEEF; ack 3 cycles after csr_req.
  - Expect csr_addr=0x0004, csr_we=1, csr_wdata=0xDEADBEEF.
  - Expect rsp_err=0, rsp_rdata=0.
- Read: cmd_addr=0x0000_0008; ack with csr_rdata=0x1234_5678.
  - Expect csr_addr=0x0002.
  - Expect rsp_rdata=0x12345678, rsp_valid 1 cycle after ack.
- Timeout: TIMEOUT_CYCLES=8, no ack.
  - Expect csr_req high 8 cycles then low.
  - Expect rsp_err=1, rsp_rdata=0.
- Illegal address: cmd_addr=0x0004_0000 and cmd_addr=0x0000_0002.
  - Expect no csr_req and rsp_err=1.
  - Expect stat_addr_err_cnt=2 when the macro is defined.
- Backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles: rsp_valid/rsp_rdata stay stable and cmd_ready=0.
  - Assert rst_n=0 during WAIT: csr_req drops asynchronously and no response appears after reset.
